// File: rtl/life_engine_seq.sv
// Row-serial Game of Life engine: one board row is evaluated per clock from a
// snapshot of the input board, so a full generation takes ROWS compute cycles.
module life_engine_seq #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16,
  localparam int POP_W = $clog2(ROWS*COLS+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [POP_W-1:0]     population,
  output logic [GEN_W-1:0]     gen_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t            state_reg, state_next;
  logic              load, last_row;
  logic [CELLS-1:0]  cur_reg, nxt_reg, nxt_shift;
  logic [RW-1:0]     row_reg, row_up_idx, row_dn_idx;
  logic [POP_W-1:0]  pop_acc_reg, pop_sum;
  logic [COLS-1:0]   row_up, row_mid, row_dn, new_row;
  logic [CW-1:0]     row_pop;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: if (row_reg == LAST_ROW) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == COMPUTE);
    load     = (state_reg == IDLE) && start;
    last_row = (state_reg == COMPUTE) && (row_reg == LAST_ROW);
  end

  // Neighbour rows; at the top/bottom edge they either wrap or read as dead.
  always_comb begin
    row_up_idx = (row_reg == '0) ? LAST_ROW : row_reg - RW'(1);
    row_dn_idx = (row_reg == LAST_ROW) ? '0 : row_reg + RW'(1);
    row_mid    = cur_reg[row_reg*COLS +: COLS];
    row_up     = cur_reg[row_up_idx*COLS +: COLS];
    row_dn     = cur_reg[row_dn_idx*COLS +: COLS];
    if (WRAP == 0 && row_reg == '0)      row_up = '0;
    if (WRAP == 0 && row_reg == LAST_ROW) row_dn = '0;
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
    localparam int CL  = (gi == 0) ? COLS - 1 : gi - 1;
    localparam int CR  = (gi == COLS - 1) ? 0 : gi + 1;
    localparam bit LOK = (WRAP != 0) || (gi != 0);
    localparam bit ROK = (WRAP != 0) || (gi != COLS - 1);
    logic [7:0] nb;
    logic [3:0] n;
    assign nb = {LOK ? row_up[CL] : 1'b0, row_up[gi], ROK ? row_up[CR] : 1'b0,
                 LOK ? row_mid[CL] : 1'b0,            ROK ? row_mid[CR] : 1'b0,
                 LOK ? row_dn[CL] : 1'b0, row_dn[gi], ROK ? row_dn[CR] : 1'b0};
    assign n = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3])
             + 4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);
    assign new_row[gi] = (n == 4'd3) || (row_mid[gi] && n == 4'd2);
  end

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < COLS; i++) row_pop = row_pop + CW'(new_row[i]);
  end

  // Rows enter at the top and shift down; after ROWS steps row r sits at slot r.
  assign nxt_shift = {new_row, nxt_reg[CELLS-1:COLS]};
  assign pop_sum   = pop_acc_reg + POP_W'(row_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg     <= '0;
      nxt_reg     <= '0;
      row_reg     <= '0;
      pop_acc_reg <= '0;
      board_out   <= '0;
      population  <= '0;
      gen_count   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cur_reg     <= board_in;
        row_reg     <= '0;
        pop_acc_reg <= '0;
      end else if (busy) begin
        nxt_reg     <= nxt_shift;
        pop_acc_reg <= pop_sum;
        row_reg     <= row_reg + RW'(1);
        if (last_row) begin
          board_out  <= nxt_shift;
          population <= pop_sum;
          gen_count  <= gen_count + GEN_W'(1);
          done       <= 1'b1;
          row_reg    <= '0;
        end
      end
    end
  end

endmodule
